// File: rtl/aq_djpeg_ycbcr_sched.sv
// ============================================================================
// Module   : aq_djpeg_ycbcr_sched
// Purpose  : Sequencer between the IDCT output stage and the YCbCr->RGB
//            converter. Tracks which colour block of the current MCU the IDCT
//            is writing, owns the two-bank ping-pong MCU buffer bookkeeping,
//            and issues the 0..2^ADDR_W-1 conversion read sweep for every
//            completed MCU, advancing the MCU X/Y position per sweep.
// Ports    : clk, rst (async, active-high), ProcessInit_i (sync restart)
//            JpegComp_i, DataInEnable_i, DataInPage_i, DataInCount_i,
//            DataInBlockWidth_i, ConvertStall_i                 -> inputs
//            DataInColor_o, DataInBank_o, DataInFull_o          -> write side
//            ConvertEnable_o, ConvertRead_o, ConvertBank_o,
//            ConvertAddress_o, ConvertBlockX_o, ConvertBlockY_o -> read side
//            OverflowErr_o (only with AQ_DJPEG_SCHED_ERR_EN defined)
// Options  : AQ_DJPEG_SCHED_ERR_EN - adds the sticky OverflowErr_o flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aq_djpeg_ycbcr_sched #(
  parameter int ADDR_W = 8,
  parameter int BLK_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ProcessInit_i,
  input  logic [2:0]        JpegComp_i,
  input  logic              DataInEnable_i,
  input  logic [2:0]        DataInPage_i,
  input  logic [1:0]        DataInCount_i,
  input  logic [BLK_W-1:0]  DataInBlockWidth_i,
  input  logic              ConvertStall_i,
  output logic [2:0]        DataInColor_o,
  output logic              DataInBank_o,
  output logic              DataInFull_o,
  output logic              ConvertEnable_o,
  output logic              ConvertRead_o,
  output logic              ConvertBank_o,
  output logic [ADDR_W-1:0] ConvertAddress_o,
  output logic [BLK_W-1:0]  ConvertBlockX_o,
  output logic [BLK_W-1:0]  ConvertBlockY_o
`ifdef AQ_DJPEG_SCHED_ERR_EN
  ,
  output logic              OverflowErr_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Write side state
  // --------------------------------------------------------------------------
  logic [2:0] color_q, color_d;
  logic       in_bank_q, in_bank_d;
  logic [1:0] valid_q, valid_d;

  // --------------------------------------------------------------------------
  // Read side state
  // --------------------------------------------------------------------------
  state_t            state_q;
  logic              enable_q;
  logic              cv_bank_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BLK_W-1:0]  blk_x_q;
  logic [BLK_W-1:0]  blk_y_q;

  logic             w_full;
  logic             w_blk_end;
  logic             w_last_color;
  logic             w_read;
  logic [BLK_W-1:0] w_x_inc;
  logic             w_x_wrap;

  assign w_full = valid_q[0] & valid_q[1];

  // Writes arriving while both banks are occupied are dropped entirely.
  assign w_blk_end = DataInEnable_i & (DataInPage_i == 3'd7) &
                     (DataInCount_i == 2'd3) & ~w_full;

  // Greyscale MCUs carry 4 luma blocks; every other component count is
  // handled as 4:2:0 colour (4 Y + Cb + Cr). The >= comparison keeps the
  // counter bounded if JpegComp changes while an MCU is half written.
  assign w_last_color = (JpegComp_i == 3'd1) ? (color_q >= 3'd3)
                                             : (color_q >= 3'd5);

  always_comb begin
    color_d   = color_q;
    in_bank_d = in_bank_q;
    valid_d   = valid_q;
    // Release the bank that just finished converting. The write side can
    // never be completing that same bank, so the two updates don't collide.
    if (state_q == S_DONE) begin
      valid_d[cv_bank_q] = 1'b0;
    end
    if (w_blk_end) begin
      if (w_last_color) begin
        color_d            = 3'd0;
        in_bank_d          = ~in_bank_q;
        valid_d[in_bank_q] = 1'b1;
      end else begin
        color_d = color_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_q   <= 3'd0;
      in_bank_q <= 1'b0;
      valid_q   <= 2'b00;
    end else if (ProcessInit_i) begin
      color_q   <= 3'd0;
      in_bank_q <= 1'b0;
      valid_q   <= 2'b00;
    end else begin
      color_q   <= color_d;
      in_bank_q <= in_bank_d;
      valid_q   <= valid_d;
    end
  end

`ifdef AQ_DJPEG_SCHED_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (ProcessInit_i) begin
      err_q <= 1'b0;
    end else if (DataInEnable_i & w_full) begin
      err_q <= 1'b1;
    end
  end

  assign OverflowErr_o = err_q;
`endif

  // --------------------------------------------------------------------------
  // Conversion sweep FSM
  // --------------------------------------------------------------------------
  assign w_read = (state_q == S_READ) & ~ConvertStall_i;

  // Width 0 never matches an in-range X+1 except at the counter overflow,
  // so it behaves as a full 2^BLK_W-wide row without a special case.
  assign w_x_inc  = blk_x_q + 1'b1;
  assign w_x_wrap = (w_x_inc == DataInBlockWidth_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      enable_q  <= 1'b0;
      cv_bank_q <= 1'b0;
      addr_q    <= '0;
      blk_x_q   <= '0;
      blk_y_q   <= '0;
    end else if (ProcessInit_i) begin
      state_q   <= S_IDLE;
      enable_q  <= 1'b0;
      cv_bank_q <= 1'b0;
      addr_q    <= '0;
      blk_x_q   <= '0;
      blk_y_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_q[cv_bank_q]) begin
            state_q  <= S_READ;
            enable_q <= 1'b1;
            addr_q   <= '0;
          end
        end
        S_READ: begin
          if (w_read) begin
            addr_q <= addr_q + 1'b1;
            if (addr_q == {ADDR_W{1'b1}}) begin
              state_q  <= S_DONE;
              enable_q <= 1'b0;
            end
          end
        end
        S_DONE: begin
          cv_bank_q <= ~cv_bank_q;
          if (w_x_wrap) begin
            blk_x_q <= '0;
            blk_y_q <= blk_y_q + 1'b1;
          end else begin
            blk_x_q <= w_x_inc;
          end
          state_q <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign DataInColor_o    = color_q;
  assign DataInBank_o     = in_bank_q;
  assign DataInFull_o     = w_full;
  assign ConvertEnable_o  = enable_q;
  assign ConvertRead_o    = w_read;
  assign ConvertBank_o    = cv_bank_q;
  assign ConvertAddress_o = addr_q;
  assign ConvertBlockX_o  = blk_x_q;
  assign ConvertBlockY_o  = blk_y_q;

endmodule

`default_nettype wire
